// File: rtl/cv32e40x_rvfi_pkg.sv
// Shared RVFI types for the cv32e40x bench: memory error causes.
package cv32e40x_rvfi_pkg;

    typedef enum logic [1:0] {
        MEM_ERR_IO_ALIGN = 2'h0,
        MEM_ERR_ATOMIC   = 2'h1,
        MEM_ERR_PMP      = 2'h2,
        MEM_ERR_BUS      = 2'h3
    } mem_err_t;

endpackage

// File: rtl/rvfi_mem_resp_fifo.sv
// In-order response tracker: each entry names the slot an outstanding bus
// request will fill and whether that slot still belongs to the live instruction.
module rvfi_mem_resp_fifo #(
    parameter int DEPTH = 2,
    parameter int SW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [SW-1:0] push_slot,
    input  logic          push_live,
    input  logic          pop,
    input  logic          clear_live,
    output logic          empty,
    output logic          full,
    output logic [SW-1:0] head_slot,
    output logic          head_live,
    output logic          live_pending
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][SW-1:0] slot_q;
    logic [DEPTH-1:0]         live_q;
    logic [DEPTH-1:0]         head_mask;
    logic [PW-1:0]            rd_ptr, wr_ptr;
    logic [CW-1:0]            count;
    logic                     do_pop, do_push;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign do_pop    = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push   = push && (!full || do_pop);
    assign head_slot = slot_q[rd_ptr];
    assign head_live = live_q[rd_ptr];
    assign head_mask = DEPTH'(1) << rd_ptr;
    // Live entries that will still be waiting after this cycle's pop.
    assign live_pending = |(live_q & ~(do_pop ? head_mask : '0));

    // Pointer/occupancy update; the new push is written after clear so it stays live.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q <= '0;
            live_q <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (clear_live) live_q <= '0;
            if (do_pop) begin
                live_q[rd_ptr] <= 1'b0;
                rd_ptr         <= inc(rd_ptr);
            end
            if (do_push) begin
                slot_q[wr_ptr] <= push_slot;
                live_q[wr_ptr] <= push_live;
                wr_ptr         <= inc(wr_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rvfi_mem_tracker.sv
// Accumulates up to NMEM data-side transactions per instruction and emits one
// registered record per retirement.
module rvfi_mem_tracker
    import cv32e40x_rvfi_pkg::*;
#(
    parameter int NMEM       = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int OUTSTND    = 2,
    localparam int BW        = DATA_WIDTH / 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid_i,
    input  logic [ADDR_WIDTH-1:0]      req_addr_i,
    input  logic                       req_we_i,
    input  logic [BW-1:0]              req_be_i,
    input  logic [DATA_WIDTH-1:0]      req_wdata_i,
    input  logic                       blk_valid_i,
    input  logic [1:0]                 blk_type_i,
    input  logic                       rvalid_i,
    input  logic [DATA_WIDTH-1:0]      rdata_i,
    input  logic                       err_i,
    input  logic                       retire_i,
    input  logic                       kill_i,
    output logic                       rvfi_valid_o,
    output logic [NMEM*ADDR_WIDTH-1:0] rvfi_mem_addr_o,
    output logic [NMEM*BW-1:0]         rvfi_mem_rmask_o,
    output logic [NMEM*BW-1:0]         rvfi_mem_wmask_o,
    output logic [NMEM*DATA_WIDTH-1:0] rvfi_mem_rdata_o,
    output logic [NMEM*DATA_WIDTH-1:0] rvfi_mem_wdata_o,
    output logic [NMEM-1:0]            rvfi_mem_err_o,
    output logic [NMEM*2-1:0]          rvfi_mem_err_type_o,
    output logic [$clog2(NMEM+1)-1:0]  rvfi_mem_cnt_o,
    output logic                       rvfi_mem_ovf_o,
    output logic                       protocol_err_o
);
    localparam int CW = $clog2(NMEM + 1);
    localparam int SW = (NMEM > 1) ? $clog2(NMEM) : 1;
    localparam logic [CW-1:0] NMEM_C = CW'(NMEM);

    logic [NMEM-1:0][ADDR_WIDTH-1:0] acc_addr, nxt_addr;
    logic [NMEM-1:0][BW-1:0]         acc_rmask, nxt_rmask, acc_wmask, nxt_wmask;
    logic [NMEM-1:0][DATA_WIDTH-1:0] acc_rdata, mrg_rdata, nxt_rdata, acc_wdata, nxt_wdata;
    logic [NMEM-1:0]                 acc_err, mrg_err, nxt_err, acc_we, nxt_we;
    logic [NMEM-1:0][1:0]            acc_type, mrg_type, nxt_type;
    logic [CW-1:0]                   cnt, base_cnt, nxt_cnt;
    logic                            ovf, nxt_ovf;
    logic                            flush, req_any, blk_only, slot_ok, pop, perr_set;
    logic [SW-1:0]                   wr_slot, head_slot;
    logic                            fifo_empty, fifo_full, head_live, live_pending;

    // Retire and kill both start a fresh instruction; a same-cycle request lands in slot 0.
    assign flush    = retire_i || kill_i;
    assign req_any  = req_valid_i || blk_valid_i;
    assign blk_only = blk_valid_i && !req_valid_i;
    assign base_cnt = flush ? '0 : cnt;
    assign slot_ok  = (base_cnt < NMEM_C);
    assign wr_slot  = base_cnt[SW-1:0];
    assign pop      = rvalid_i && !fifo_empty;

    assign perr_set = (req_valid_i && blk_valid_i)
                    || (rvalid_i && fifo_empty)
                    || (req_valid_i && fifo_full && !pop)
                    || (retire_i && live_pending);

    rvfi_mem_resp_fifo #(.DEPTH(OUTSTND), .SW(SW)) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push         (req_valid_i),
        .push_slot    (wr_slot),
        .push_live    (slot_ok),
        .pop          (rvalid_i),
        .clear_live   (flush),
        .empty        (fifo_empty),
        .full         (fifo_full),
        .head_slot    (head_slot),
        .head_live    (head_live),
        .live_pending (live_pending)
    );

    // Fold this cycle's response into the accumulator, then apply the new request.
    always_comb begin
        mrg_rdata = acc_rdata;
        mrg_err   = acc_err;
        mrg_type  = acc_type;
        if (pop && head_live) begin
            if (!acc_we[head_slot]) mrg_rdata[head_slot] = rdata_i;
            if (err_i) begin
                mrg_err[head_slot]  = 1'b1;
                mrg_type[head_slot] = MEM_ERR_BUS;
            end
        end
        nxt_addr  = flush ? '0 : acc_addr;
        nxt_rmask = flush ? '0 : acc_rmask;
        nxt_wmask = flush ? '0 : acc_wmask;
        nxt_rdata = flush ? '0 : mrg_rdata;
        nxt_wdata = flush ? '0 : acc_wdata;
        nxt_err   = flush ? '0 : mrg_err;
        nxt_type  = flush ? '0 : mrg_type;
        nxt_we    = flush ? '0 : acc_we;
        nxt_ovf   = flush ? 1'b0 : ovf;
        nxt_cnt   = base_cnt;
        if (req_any) begin
            if (slot_ok) begin
                nxt_addr[wr_slot]  = req_addr_i;
                nxt_we[wr_slot]    = req_we_i;
                nxt_rmask[wr_slot] = req_we_i ? '0 : req_be_i;
                nxt_wmask[wr_slot] = req_we_i ? req_be_i : '0;
                nxt_wdata[wr_slot] = req_we_i ? req_wdata_i : '0;
                nxt_rdata[wr_slot] = '0;
                nxt_err[wr_slot]   = blk_only;
                nxt_type[wr_slot]  = blk_only ? blk_type_i : 2'b00;
                nxt_cnt            = base_cnt + CW'(1);
            end else begin
                nxt_ovf = 1'b1;
            end
        end
    end

    // Accumulator state for the instruction currently in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_addr  <= '0;
            acc_rmask <= '0;
            acc_wmask <= '0;
            acc_rdata <= '0;
            acc_wdata <= '0;
            acc_err   <= '0;
            acc_type  <= '0;
            acc_we    <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
        end else begin
            acc_addr  <= nxt_addr;
            acc_rmask <= nxt_rmask;
            acc_wmask <= nxt_wmask;
            acc_rdata <= nxt_rdata;
            acc_wdata <= nxt_wdata;
            acc_err   <= nxt_err;
            acc_type  <= nxt_type;
            acc_we    <= nxt_we;
            cnt       <= nxt_cnt;
            ovf       <= nxt_ovf;
        end
    end

    // Output record: captured on retire (including the same-cycle response), held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            rvfi_valid_o        <= 1'b0;
            rvfi_mem_addr_o     <= '0;
            rvfi_mem_rmask_o    <= '0;
            rvfi_mem_wmask_o    <= '0;
            rvfi_mem_rdata_o    <= '0;
            rvfi_mem_wdata_o    <= '0;
            rvfi_mem_err_o      <= '0;
            rvfi_mem_err_type_o <= '0;
            rvfi_mem_cnt_o      <= '0;
            rvfi_mem_ovf_o      <= 1'b0;
            protocol_err_o      <= 1'b0;
        end else begin
            rvfi_valid_o   <= retire_i;
            protocol_err_o <= protocol_err_o | perr_set;
            if (retire_i) begin
                rvfi_mem_addr_o     <= acc_addr;
                rvfi_mem_rmask_o    <= acc_rmask;
                rvfi_mem_wmask_o    <= acc_wmask;
                rvfi_mem_rdata_o    <= mrg_rdata;
                rvfi_mem_wdata_o    <= acc_wdata;
                rvfi_mem_err_o      <= mrg_err;
                rvfi_mem_err_type_o <= mrg_type;
                rvfi_mem_cnt_o      <= cnt;
                rvfi_mem_ovf_o      <= ovf;
            end
        end
    end

endmodule

// File: tb/tb_rvfi_mem_tracker.sv
// Self-checking bench for rvfi_mem_tracker: table of cycle vectors with
// expected records queued on retire and compared when rvfi_valid_o appears.
module tb_rvfi_mem_tracker;
    localparam int NMEM = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int BW   = DW / 8;
    localparam int CW   = $clog2(NMEM + 1);

    typedef struct packed {
        logic [CW-1:0]           cnt;
        logic                    ovf;
        logic [NMEM-1:0][AW-1:0] addr;
        logic [NMEM-1:0][BW-1:0] rmask;
        logic [NMEM-1:0][BW-1:0] wmask;
        logic [NMEM-1:0][DW-1:0] rdata;
        logic [NMEM-1:0][DW-1:0] wdata;
        logic [NMEM-1:0]         err;
        logic [NMEM-1:0][1:0]    etype;
    } rec_t;

    typedef struct {
        logic          req;
        logic [AW-1:0] addr;
        logic          we;
        logic [BW-1:0] be;
        logic [DW-1:0] wdata;
        logic          blk;
        logic [1:0]    btype;
        logic          rv;
        logic [DW-1:0] rdata;
        logic          err;
        logic          retire;
        logic          kill;
        logic          exp_pe;
        rec_t          exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic req_valid, req_we, blk_valid, rvalid, err, retire, kill;
    logic [AW-1:0] req_addr;
    logic [BW-1:0] req_be;
    logic [DW-1:0] req_wdata, rdata;
    logic [1:0] blk_type;
    logic rvfi_valid, rvfi_ovf, protocol_err;
    logic [NMEM*AW-1:0] rvfi_addr;
    logic [NMEM*BW-1:0] rvfi_rmask, rvfi_wmask;
    logic [NMEM*DW-1:0] rvfi_rdata, rvfi_wdata;
    logic [NMEM-1:0] rvfi_err;
    logic [NMEM*2-1:0] rvfi_etype;
    logic [CW-1:0] rvfi_cnt;

    int checks = 0;
    int failures = 0;
    rec_t exp_q[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    rvfi_mem_tracker #(.NMEM(NMEM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUTSTND(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_addr_i(req_addr), .req_we_i(req_we),
        .req_be_i(req_be), .req_wdata_i(req_wdata),
        .blk_valid_i(blk_valid), .blk_type_i(blk_type),
        .rvalid_i(rvalid), .rdata_i(rdata), .err_i(err),
        .retire_i(retire), .kill_i(kill),
        .rvfi_valid_o(rvfi_valid), .rvfi_mem_addr_o(rvfi_addr),
        .rvfi_mem_rmask_o(rvfi_rmask), .rvfi_mem_wmask_o(rvfi_wmask),
        .rvfi_mem_rdata_o(rvfi_rdata), .rvfi_mem_wdata_o(rvfi_wdata),
        .rvfi_mem_err_o(rvfi_err), .rvfi_mem_err_type_o(rvfi_etype),
        .rvfi_mem_cnt_o(rvfi_cnt), .rvfi_mem_ovf_o(rvfi_ovf),
        .protocol_err_o(protocol_err)
    );

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic vec_t v(input logic req, input logic [AW-1:0] addr, input logic we,
                               input logic [BW-1:0] be, input logic [DW-1:0] wd,
                               input logic rv, input logic [DW-1:0] rd, input logic er,
                               input logic ret, input logic kl);
        vec_t t;
        t.req = req; t.addr = addr; t.we = we; t.be = be; t.wdata = wd;
        t.blk = 1'b0; t.btype = 2'b00;
        t.rv = rv; t.rdata = rd; t.err = er; t.retire = ret; t.kill = kl;
        t.exp_pe = 1'b0; t.exp = '0;
        return t;
    endfunction

    function automatic rec_t put(input rec_t r, input int s, input logic [AW-1:0] a,
                                 input logic [BW-1:0] rm, input logic [BW-1:0] wm,
                                 input logic [DW-1:0] rd, input logic [DW-1:0] wd,
                                 input logic e, input logic [1:0] et);
        rec_t o = r;
        o.addr[s] = a; o.rmask[s] = rm; o.wmask[s] = wm;
        o.rdata[s] = rd; o.wdata[s] = wd; o.err[s] = e; o.etype[s] = et;
        return o;
    endfunction

    task automatic idle_inputs();
        req_valid = 0; req_addr = '0; req_we = 0; req_be = '0; req_wdata = '0;
        blk_valid = 0; blk_type = '0; rvalid = 0; rdata = '0; err = 0;
        retire = 0; kill = 0;
    endtask

    task automatic compare_rec(input rec_t e);
        check("cnt", 128'(rvfi_cnt), 128'(e.cnt));
        check("ovf", 128'(rvfi_ovf), 128'(e.ovf));
        check("addr", 128'(rvfi_addr), 128'(e.addr));
        check("rmask", 128'(rvfi_rmask), 128'(e.rmask));
        check("wmask", 128'(rvfi_wmask), 128'(e.wmask));
        check("rdata", 128'(rvfi_rdata), 128'(e.rdata));
        check("wdata", 128'(rvfi_wdata), 128'(e.wdata));
        check("err", 128'(rvfi_err), 128'(e.err));
        check("err_type", 128'(rvfi_etype), 128'(e.etype));
    endtask

    // Drive one cycle, then sample 1 time unit after the edge.
    task automatic step(input vec_t t);
        req_valid = t.req; req_addr = t.addr; req_we = t.we; req_be = t.be;
        req_wdata = t.wdata; blk_valid = t.blk; blk_type = t.btype;
        rvalid = t.rv; rdata = t.rdata; err = t.err; retire = t.retire; kill = t.kill;
        if (t.retire) exp_q.push_back(t.exp);
        @(posedge clk); #1;
        idle_inputs();
        check("protocol_err", 128'(protocol_err), 128'(t.exp_pe));
        check("valid", 128'(rvfi_valid), 128'(exp_q.size() != 0));
        if (rvfi_valid && exp_q.size() != 0) compare_rec(exp_q.pop_front());
        else exp_q.delete();
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_valid"}, 128'(rvfi_valid), 128'(0));
        check({nm, "_pe"}, 128'(protocol_err), 128'(0));
        compare_rec('0);
    endtask

    // Reset with a request asserted to show that reset overrides inputs.
    task automatic do_reset();
        idle_inputs();
        rst = 1; req_valid = 1; req_addr = 32'hD00; req_be = 4'hF;
        @(posedge clk); #1;
        rst = 0; idle_inputs();
        exp_q.delete();
        check_all_zero("reset");
    endtask

    initial begin : main
        vec_t t;
        rec_t r;
        idle_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        check_all_zero("por");

        // Single load
        tbl.push_back(v(1, 32'h100, 0, 4'hF, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0, 0));
        t = v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        r = '0; r.cnt = 1; r = put(r, 0, 32'h100, 4'hF, 4'h0, 32'hDEADBEEF, 0, 0, 0);
        t.exp = r; tbl.push_back(t);
        // Two outstanding stores
        tbl.push_back(v(1, 32'h200, 1, 4'h3, 32'h1234, 0, 0, 0, 0, 0));
        tbl.push_back(v(1, 32'h204, 1, 4'hC, 32'h5678, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 32'hFFFF0000, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 32'hFFFF0001, 0, 0, 0));
        t = v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        r = '0; r.cnt = 2;
        r = put(r, 0, 32'h200, 4'h0, 4'h3, 0, 32'h1234, 0, 0);
        r = put(r, 1, 32'h204, 4'h0, 4'hC, 0, 32'h5678, 0, 0);
        t.exp = r; tbl.push_back(t);
        // PMP block
        t = v(0, 32'h300, 0, 4'hF, 0, 0, 0, 0, 0, 0); t.blk = 1; t.btype = 2'd2;
        tbl.push_back(t);
        t = v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        r = '0; r.cnt = 1; r = put(r, 0, 32'h300, 4'hF, 4'h0, 0, 0, 1, 2'd2);
        t.exp = r; tbl.push_back(t);
        // NMEM+1 requests, pushes at full occupancy with same-cycle pops
        tbl.push_back(v(1, 32'h400, 0, 4'hF, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(1, 32'h404, 0, 4'hF, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(1, 32'h408, 0, 4'hF, 0, 1, 32'hA0, 0, 0, 0));
        tbl.push_back(v(1, 32'h40C, 0, 4'hF, 0, 1, 32'hA1, 0, 0, 0));
        tbl.push_back(v(1, 32'h410, 0, 4'hF, 0, 1, 32'hA2, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 32'hA3, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 32'hBAD, 0, 0, 0));
        t = v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        r = '0; r.cnt = 4; r.ovf = 1;
        for (int i = 0; i < 4; i++) r = put(r, i, 32'h400 + 32'(4 * i), 4'hF, 4'h0, 32'hA0 + 32'(i), 0, 0, 0);
        t.exp = r; tbl.push_back(t);
        // Kill, then stale erroring response, then new load
        tbl.push_back(v(1, 32'h500, 0, 4'hF, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 32'hBAD, 1, 0, 0));
        tbl.push_back(v(1, 32'h600, 0, 4'hF, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 32'h66, 0, 0, 0));
        t = v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        r = '0; r.cnt = 1; r = put(r, 0, 32'h600, 4'hF, 4'h0, 32'h66, 0, 0, 0);
        t.exp = r; tbl.push_back(t);
        // Same-cycle response + retire + next request; then back-to-back retires
        tbl.push_back(v(1, 32'h800, 0, 4'hF, 0, 0, 0, 0, 0, 0));
        t = v(1, 32'h900, 0, 4'h1, 0, 1, 32'h88, 0, 1, 0);
        r = '0; r.cnt = 1; r = put(r, 0, 32'h800, 4'hF, 4'h0, 32'h88, 0, 0, 0);
        t.exp = r; tbl.push_back(t);
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 32'h99, 0, 0, 0));
        t = v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        r = '0; r.cnt = 1; r = put(r, 0, 32'h900, 4'h1, 4'h0, 32'h99, 0, 0, 0);
        t.exp = r; tbl.push_back(t);
        t = v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); t.exp = '0; tbl.push_back(t);
        // Retire wins over kill; response with err_i sets bus error on a store
        tbl.push_back(v(1, 32'hA00, 1, 4'hF, 32'hAA, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 32'h77, 1, 0, 0));
        t = v(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        r = '0; r.cnt = 1; r = put(r, 0, 32'hA00, 4'h0, 4'hF, 0, 32'hAA, 1, 2'd3);
        t.exp = r; tbl.push_back(t);

        foreach (tbl[i]) step(tbl[i]);

        // rvalid with empty FIFO: sticky protocol error
        t = v(0, 0, 0, 0, 0, 1, 32'h1, 0, 0, 0); t.exp_pe = 1; step(t);
        t = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); t.exp_pe = 1; step(t);
        do_reset();

        // Retire with one outstanding: protocol error, rdata stays 0, late rvalid ignored
        tbl.delete();
        step(v(1, 32'hB00, 0, 4'hF, 0, 0, 0, 0, 0, 0));
        t = v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); t.exp_pe = 1;
        r = '0; r.cnt = 1; r = put(r, 0, 32'hB00, 4'hF, 4'h0, 0, 0, 0, 0);
        t.exp = r; step(t);
        t = v(0, 0, 0, 0, 0, 1, 32'hCC, 0, 0, 0); t.exp_pe = 1; step(t);

        // Reset mid-accumulation, then an empty record
        t = v(1, 32'hC00, 0, 4'hF, 0, 0, 0, 0, 0, 0); t.exp_pe = 1; step(t);
        do_reset();
        t = v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); t.exp = '0; step(t);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the bench always ends.
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
